// File: rtl/bcd_print_ctrl.sv
// bcd_print_ctrl: drives one binary-to-BCD converter and streams the result
// as decimal ASCII (optional '-', digits, optional CR/LF) to a UART TX sink.
module bcd_print_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter bit PAD_ZEROS   = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_data_i,
    input  logic        req_signed_i,
    input  logic        req_eol_i,
    output logic        cvt_stb_o,
    output logic        cvt_sign_en_o,
    output logic [31:0] cvt_din_o,
    input  logic [39:0] cvt_bcd_i,
    input  logic        cvt_done_i,
    input  logic        cvt_neg_i,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        SIGN,
        DIGIT,
        CR,
        LF,
        FIN
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    state_t      state;
    logic [39:0] bcd;
    logic [3:0]  idx;
    logic        eol;
    logic [7:0]  cnt;
    logic [3:0]  scan_idx;
    logic        cvt_is_neg;

    // Position of the most significant nonzero digit, 0 when all are zero.
    function automatic logic [3:0] lead_idx(input logic [39:0] b);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (b[i*4 +: 4] != 4'd0) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

    // ASCII for digit i; out-of-range nibbles pass through unchecked.
    function automatic logic [7:0] ascii(input logic [39:0] b,
                                         input logic [3:0]  i);
        return 8'h30 + {4'h0, b[{i, 2'b00} +: 4]};
    endfunction

    // First digit to print once the converter reports.
    always_comb begin
        scan_idx   = PAD_ZEROS ? 4'd9 : lead_idx(cvt_bcd_i);
        cvt_is_neg = cvt_neg_i & cvt_sign_en_o;
    end

    // Request sequencing, converter handshake and byte streaming.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            req_ready_o   <= 1'b1;
            cvt_stb_o     <= 1'b0;
            cvt_sign_en_o <= 1'b0;
            cvt_din_o     <= '0;
            tx_valid_o    <= 1'b0;
            tx_data_o     <= '0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            bcd           <= '0;
            idx           <= '0;
            eol           <= 1'b0;
            cnt           <= '0;
        end else begin
            cvt_stb_o <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        cvt_din_o     <= req_data_i;
                        cvt_sign_en_o <= req_signed_i;
                        eol           <= req_eol_i;
                        req_ready_o   <= 1'b0;
                        cvt_stb_o     <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cvt_done_i) begin
                        bcd        <= cvt_bcd_i;
                        idx        <= scan_idx;
                        tx_valid_o <= 1'b1;
                        if (cvt_is_neg) begin
                            tx_data_o <= CH_MINUS;
                            state     <= SIGN;
                        end else begin
                            tx_data_o <= ascii(cvt_bcd_i, scan_idx);
                            state     <= DIGIT;
                        end
                    end else if (cnt == CNT_LAST) begin
                        err_o       <= 1'b1;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SIGN: begin
                    if (tx_ready_i) begin
                        tx_data_o <= ascii(bcd, idx);
                        state     <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (tx_ready_i) begin
                        if (idx != 4'd0) begin
                            idx       <= idx - 4'd1;
                            tx_data_o <= ascii(bcd, idx - 4'd1);
                        end else if (eol) begin
                            tx_data_o <= CH_CR;
                            state     <= CR;
                        end else begin
                            tx_valid_o <= 1'b0;
                            tx_data_o  <= '0;
                            done_o     <= 1'b1;
                            state      <= FIN;
                        end
                    end
                end
                CR: begin
                    if (tx_ready_i) begin
                        tx_data_o <= CH_LF;
                        state     <= LF;
                    end
                end
                LF: begin
                    if (tx_ready_i) begin
                        tx_valid_o <= 1'b0;
                        tx_data_o  <= '0;
                        done_o     <= 1'b1;
                        state      <= FIN;
                    end
                end
                FIN: begin
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    tx_valid_o  <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_print_ctrl.sv
// tb_bcd_print_ctrl: table vectors, corner sequences and random requests
// for bcd_print_ctrl, unpadded and zero-padded instances side by side.
module tb_bcd_print_ctrl;

    localparam int TO = 64;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] d;
        bit          s;
        bit          e;
        string       w0;
        string       w1;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_data = '0;
    logic        req_signed = 1'b0;
    logic        req_eol = 1'b0;
    logic [39:0] cvt_bcd = '0;
    logic        cvt_done = 1'b0;
    logic        cvt_neg = 1'b0;
    logic        tx_ready = 1'b1;

    logic        rdy0, stb0, sgn0, txv0, done0, err0;
    logic [31:0] din0;
    logic [7:0]  txd0;
    logic        rdy1, stb1, sgn1, txv1, done1, err1;
    logic [31:0] din1;
    logic [7:0]  txd1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;
    bit withhold = 1'b0;
    string crlf;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_print_ctrl #(.TIMEOUT_CYC(TO), .PAD_ZEROS(1'b0)) u0 (
        .clk(clk), .resetn(resetn),
        .req_valid_i(req_valid), .req_ready_o(rdy0),
        .req_data_i(req_data), .req_signed_i(req_signed),
        .req_eol_i(req_eol),
        .cvt_stb_o(stb0), .cvt_sign_en_o(sgn0), .cvt_din_o(din0),
        .cvt_bcd_i(cvt_bcd), .cvt_done_i(cvt_done), .cvt_neg_i(cvt_neg),
        .tx_valid_o(txv0), .tx_ready_i(tx_ready), .tx_data_o(txd0),
        .done_o(done0), .err_o(err0)
    );

    bcd_print_ctrl #(.TIMEOUT_CYC(TO), .PAD_ZEROS(1'b1)) u1 (
        .clk(clk), .resetn(resetn),
        .req_valid_i(req_valid), .req_ready_o(rdy1),
        .req_data_i(req_data), .req_signed_i(req_signed),
        .req_eol_i(req_eol),
        .cvt_stb_o(stb1), .cvt_sign_en_o(sgn1), .cvt_din_o(din1),
        .cvt_bcd_i(cvt_bcd), .cvt_done_i(cvt_done), .cvt_neg_i(cvt_neg),
        .tx_valid_o(txv1), .tx_ready_i(tx_ready), .tx_data_o(txd1),
        .done_o(done1), .err_o(err1)
    );

    // Converter stand-in: magnitude digits by repeated division.
    function automatic logic [39:0] to_bcd(input logic [31:0] d, input bit s);
        longint m;
        logic [39:0] r;
        m = (s && d[31]) ? -longint'($signed(d)) : longint'(d);
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    logic        pend;
    int          dly;
    logic [31:0] cdin;
    logic        csgn;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend     <= 1'b0;
            cvt_done <= 1'b0;
            dly      <= 0;
        end else begin
            cvt_done <= 1'b0;
            if (stb0) begin
                pend <= 1'b1;
                dly  <= $urandom_range(0, 6);
                cdin <= din0;
                csgn <= sgn0;
            end else if (pend) begin
                if (dly > 0) begin
                    dly <= dly - 1;
                end else if (!withhold) begin
                    pend     <= 1'b0;
                    cvt_done <= 1'b1;
                    cvt_bcd  <= to_bcd(cdin, csgn);
                    cvt_neg  <= csgn & cdin[31];
                end
            end
        end
    end

    // Sink ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = ($urandom_range(0, 99) < 30);
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Observation at the falling edge.
    bq_t  q0, q1;
    int   nd0 = 0, nd1 = 0, ne0 = 0, ne1 = 0, ns0 = 0;
    int   acc_cyc = 0, stb_cyc = 0, cdone_cyc = 0, err_cyc = 0;
    int   txrise_cyc = 0, done_cyc = 0, stab_bad = 0;
    bit   prev_txv0 = 1'b0, hold0 = 1'b0, hold1 = 1'b0;
    logic [7:0] pd0 = '0, pd1 = '0;

    always @(negedge clk) begin
        if (resetn) begin
            if (hold0 && (!txv0 || txd0 != pd0)) stab_bad++;
            if (hold1 && (!txv1 || txd1 != pd1)) stab_bad++;
            if (txv0 && tx_ready) q0.push_back(txd0);
            if (txv1 && tx_ready) q1.push_back(txd1);
            if (done0) begin
                nd0++;
                done_cyc = cyc;
            end
            if (done1) nd1++;
            if (err0) begin
                ne0++;
                err_cyc = cyc;
            end
            if (err1) ne1++;
            if (stb0) begin
                ns0++;
                stb_cyc = cyc;
            end
            if (req_valid && rdy0 && rdy1) acc_cyc = cyc;
            if (cvt_done) cdone_cyc = cyc;
            if (txv0 && !prev_txv0) txrise_cyc = cyc;
        end
        hold0 = resetn && txv0 && !tx_ready;
        hold1 = resetn && txv1 && !tx_ready;
        pd0 = txd0;
        pd1 = txd1;
        prev_txv0 = resetn && txv0;
    end

    task automatic check(input bit ok, input string nm,
                         input string act, input string exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s want %s", nm, act, exp);
        end
    endtask

    function automatic string seg(input bq_t q, input int from);
        string s;
        s = "";
        for (int i = from; i < q.size(); i++) s = $sformatf("%s%c", s, q[i]);
        return s;
    endfunction

    function automatic string hx(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) r = $sformatf("%s%02h", r, s[i]);
        return r;
    endfunction

    // Reference text: plain decimal rendering of the requested value.
    function automatic string model(input logic [31:0] d, input bit s,
                                    input bit e, input bit pad);
        longint v, m;
        string r;
        v = s ? longint'($signed(d)) : longint'(d);
        m = (v < 0) ? -v : v;
        r = $sformatf("%0d", m);
        if (pad) while (r.len() < 10) r = {"0", r};
        if (v < 0) r = {"-", r};
        if (e) r = {r, crlf};
        return r;
    endfunction

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (!(rdy0 && rdy1) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(t < 500, {nm, "_idle"}, "busy", "ready");
    endtask

    task automatic issue(input logic [31:0] d, input bit s, input bit e);
        req_valid  = 1'b1;
        req_data   = d;
        req_signed = s;
        req_eol    = e;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run(input logic [31:0] d, input bit s, input bit e,
                       input string w0, input string w1, input string nm);
        int t, b0, b1, d0s, d1s, s0s;
        string g0, g1;
        wait_idle(nm);
        b0  = q0.size();
        b1  = q1.size();
        d0s = nd0;
        d1s = nd1;
        s0s = ns0;
        issue(d, s, e);
        check(!rdy0 && !rdy1, {nm, "_busy"},
              $sformatf("%0b%0b", rdy0, rdy1), "00");
        t = 0;
        while (!(nd0 > d0s && nd1 > d1s) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check(t < 3000, {nm, "_done_wait"}, "no done", "done");
        g0 = seg(q0, b0);
        g1 = seg(q1, b1);
        check(g0 == w0, {nm, "_bytes"}, hx(g0), hx(w0));
        check(g1 == w1, {nm, "_bytes_pad"}, hx(g1), hx(w1));
        check(nd0 - d0s == 1 && nd1 - d1s == 1, {nm, "_done_cnt"},
              $sformatf("%0d/%0d", nd0 - d0s, nd1 - d1s), "1/1");
        check(ns0 - s0s == 1, {nm, "_stb_cnt"},
              $sformatf("%0d", ns0 - s0s), "1");
    endtask

    vec_t tbl[8];

    initial begin
        int t, b0, e0, e1;
        logic [31:0] d;
        crlf = $sformatf("%c%c", 8'h0D, 8'h0A);
        tbl[0] = '{32'd0, 1'b0, 1'b0, "0", "0000000000"};
        tbl[1] = '{32'd1234, 1'b0, 1'b1, {"1234", crlf},
                   {"0000001234", crlf}};
        tbl[2] = '{32'hFFFFFFFF, 1'b1, 1'b0, "-1", "-0000000001"};
        tbl[3] = '{32'hFFFFFFFF, 1'b0, 1'b0, "4294967295", "4294967295"};
        tbl[4] = '{32'h80000000, 1'b1, 1'b0, "-2147483648", "-2147483648"};
        tbl[5] = '{32'd7, 1'b0, 1'b0, "7", "0000000007"};
        tbl[6] = '{32'h80000000, 1'b0, 1'b1, {"2147483648", crlf},
                   {"2147483648", crlf}};
        tbl[7] = '{32'd10, 1'b1, 1'b0, "10", "0000000010"};

        repeat (3) @(posedge clk);
        #1;
        check(rdy0 && rdy1, "rst_ready", $sformatf("%0b%0b", rdy0, rdy1), "11");
        check({txv0, txv1, stb0, stb1, done0, done1, err0, err1} == 8'd0,
              "rst_ctl", $sformatf("%08b", {txv0, txv1, stb0, stb1,
              done0, done1, err0, err1}), "00000000");
        check({din0, din1, txd0, txd1, sgn0, sgn1} == '0, "rst_data",
              "nonzero", "zero");
        #1 resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run(tbl[i].d, tbl[i].s, tbl[i].e, tbl[i].w0, tbl[i].w1,
                $sformatf("vec%0d", i));
        end

        // Latency and back-to-back bytes with the sink always ready.
        ready_mode = 0;
        run(32'd1234, 1'b0, 1'b1, {"1234", crlf}, {"0000001234", crlf}, "lat");
        check(stb_cyc == acc_cyc + 1, "lat_stb",
              $sformatf("%0d", stb_cyc - acc_cyc), "1");
        check(txrise_cyc == cdone_cyc + 1, "lat_first_byte",
              $sformatf("%0d", txrise_cyc - cdone_cyc), "1");
        check(done_cyc == txrise_cyc + 6, "lat_no_bubble",
              $sformatf("%0d", done_cyc - txrise_cyc), "6");

        // Converter never answers.
        withhold = 1'b1;
        wait_idle("tmo");
        b0 = q0.size();
        e0 = ne0;
        e1 = ne1;
        issue(32'd55, 1'b0, 1'b1);
        t = 0;
        while (ne0 == e0 && t < TO + 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(ne0 - e0 == 1 && ne1 - e1 == 1, "tmo_err",
              $sformatf("%0d/%0d", ne0 - e0, ne1 - e1), "1/1");
        check(err_cyc - stb_cyc >= TO && err_cyc - stb_cyc <= TO + 2,
              "tmo_delay", $sformatf("%0d", err_cyc - stb_cyc),
              $sformatf("%0d..%0d", TO, TO + 2));
        check(q0.size() == b0 && !txv0 && !txv1, "tmo_no_bytes",
              $sformatf("%0d", q0.size() - b0), "0");
        check(rdy0 && rdy1, "tmo_ready", $sformatf("%0b%0b", rdy0, rdy1), "11");
        withhold = 1'b0;

        // Reset while a byte is stalled at the sink.
        ready_mode = 2;
        wait_idle("rst");
        issue(32'hFFFFFFFF, 1'b0, 1'b1);
        t = 0;
        while (!txv0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(txv0 && txv1, "rst_stall_valid",
              $sformatf("%0b%0b", txv0, txv1), "11");
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check(!txv0 && !txv1 && !stb0 && !stb1, "rst_mid_drop",
              $sformatf("%0b%0b", txv0, txv1), "00");
        check(rdy0 && rdy1, "rst_mid_ready",
              $sformatf("%0b%0b", rdy0, rdy1), "11");
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        ready_mode = 0;
        run(tbl[2].d, tbl[2].s, tbl[2].e, tbl[2].w0, tbl[2].w1, "post_rst");

        // Random values with a 30% duty sink.
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            bit s, e;
            case ($urandom_range(0, 3))
                0: d = $urandom_range(0, 99);
                1: d = $urandom;
                2: d = 32'h80000000 ^ $urandom_range(0, 3);
                default: d = -$urandom_range(1, 1000);
            endcase
            s = 1'($urandom_range(0, 1));
            e = 1'($urandom_range(0, 1));
            run(d, s, e, model(d, s, e, 1'b0), model(d, s, e, 1'b1),
                $sformatf("rnd%0d", i));
        end

        check(stab_bad == 0, "tx_hold_stable", $sformatf("%0d", stab_bad), "0");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
